// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared serial bus between two masters: grants the bus,
// receives a serial slave ID, holds the connection and inserts a dead cycle on handover.
module bus_arbiter #(
  parameter int SSEL_BITS = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 M1_REQ,
  input  logic                 M1_SLAVE_ADDR,
  output logic                 M1_GRANT,
  output logic                 M1_ACK,
  input  logic                 M2_REQ,
  input  logic                 M2_SLAVE_ADDR,
  output logic                 M2_GRANT,
  output logic                 M2_ACK,
  output logic [1:0]           bus_grant,
  output logic [SSEL_BITS-1:0] slave_select,
  output logic                 ERR_INVALID,
  output logic                 ERR_TIMEOUT
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR    = 2'd1;
  localparam logic [1:0] ST_CONNECT = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int CNT_W = $clog2(SSEL_BITS) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SSEL_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // owner / last_owner: 0 = Master 1, 1 = Master 2
  logic [1:0]           state, state_n;
  logic                 owner, owner_n;
  logic                 last_owner, last_owner_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_n;
  logic [SSEL_BITS-1:0] addr_shift, addr_shift_n;
  logic [SSEL_BITS-1:0] shift_next;
  logic                 owner_req, owner_bit, pick_m2;
  logic                 err_invalid_n, err_timeout_n;
  logic                 active_n, connect_n;

  assign owner_req  = owner ? M2_REQ : M1_REQ;
  assign owner_bit  = owner ? M2_SLAVE_ADDR : M1_SLAVE_ADDR;
  assign shift_next = SSEL_BITS'({addr_shift, owner_bit});
  // On a tie the master that was not served last wins
  assign pick_m2    = M2_REQ && (!M1_REQ || !last_owner);

  always_comb begin
    state_n       = state;
    owner_n       = owner;
    last_owner_n  = last_owner;
    bit_cnt_n     = bit_cnt;
    tmo_cnt_n     = tmo_cnt;
    addr_shift_n  = addr_shift;
    err_invalid_n = 1'b0;
    err_timeout_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (M1_REQ || M2_REQ) begin
          state_n      = ST_ADDR;
          owner_n      = pick_m2;
          bit_cnt_n    = '0;
          addr_shift_n = '0;
        end
      end
      ST_ADDR: begin
        if (!owner_req) begin
          state_n = ST_RELEASE;
        end else begin
          addr_shift_n = shift_next;
          bit_cnt_n    = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            if (shift_next != '0) begin
              state_n   = ST_CONNECT;
              tmo_cnt_n = '0;
            end else begin
              state_n       = ST_RELEASE;
              err_invalid_n = 1'b1;
            end
          end
        end
      end
      ST_CONNECT: begin
        // A dropped request takes priority over a coincident timeout
        if (!owner_req) begin
          state_n = ST_RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n       = ST_RELEASE;
          err_timeout_n = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        state_n      = ST_IDLE;
        last_owner_n = owner;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign connect_n = (state_n == ST_CONNECT);
  assign active_n  = (state_n == ST_ADDR) || connect_n;

  // Outputs are registered from the next state so the mux controls never glitch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      addr_shift   <= '0;
      bus_grant    <= 2'd0;
      slave_select <= '0;
      M1_GRANT     <= 1'b0;
      M2_GRANT     <= 1'b0;
      M1_ACK       <= 1'b0;
      M2_ACK       <= 1'b0;
      ERR_INVALID  <= 1'b0;
      ERR_TIMEOUT  <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      last_owner   <= last_owner_n;
      bit_cnt      <= bit_cnt_n;
      tmo_cnt      <= tmo_cnt_n;
      addr_shift   <= addr_shift_n;
      bus_grant    <= active_n ? (owner_n ? 2'd2 : 2'd1) : 2'd0;
      slave_select <= connect_n ? addr_shift_n : '0;
      M1_GRANT     <= active_n && !owner_n;
      M2_GRANT     <= active_n && owner_n;
      M1_ACK       <= connect_n && !owner_n;
      M2_ACK       <= connect_n && owner_n;
      ERR_INVALID  <= err_invalid_n;
      ERR_TIMEOUT  <= err_timeout_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int SSEL = 2;
  localparam int TMO  = 16;

  logic            CLK, RST;
  logic            M1_REQ, M1_SLAVE_ADDR, M1_GRANT, M1_ACK;
  logic            M2_REQ, M2_SLAVE_ADDR, M2_GRANT, M2_ACK;
  logic [1:0]      bus_grant;
  logic [SSEL-1:0] slave_select;
  logic            ERR_INVALID, ERR_TIMEOUT;

  int checks   = 0;
  int failures = 0;

  // Reference model: which master owns the bus (0 none, 1, 2), the ID bits
  // collected so far, whether the slave is routed, how many cycles it has been
  // connected, and whether the current cycle is the dead handover cycle.
  int m_owner, m_last, m_bits, m_id, m_cnt;
  bit m_conn, m_gap, m_err_inv, m_err_tmo;

  bus_arbiter #(.SSEL_BITS(SSEL), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .M1_REQ(M1_REQ), .M1_SLAVE_ADDR(M1_SLAVE_ADDR), .M1_GRANT(M1_GRANT), .M1_ACK(M1_ACK),
    .M2_REQ(M2_REQ), .M2_SLAVE_ADDR(M2_SLAVE_ADDR), .M2_GRANT(M2_GRANT), .M2_ACK(M2_ACK),
    .bus_grant(bus_grant), .slave_select(slave_select),
    .ERR_INVALID(ERR_INVALID), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t observed=%0d expected=%0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_owner = 0; m_last = 2; m_bits = 0; m_id = 0; m_cnt = 0;
    m_conn = 0; m_gap = 0; m_err_inv = 0; m_err_tmo = 0;
  endtask

  task automatic modelEdge(input bit r1, input bit a1, input bit r2, input bit a2);
    bit req, addr;
    m_err_inv = 0;
    m_err_tmo = 0;
    if (m_gap) begin
      m_gap = 0;
      m_last = m_owner;
      m_owner = 0;
    end else if (m_owner == 0) begin
      if (r1 || r2) begin
        if (r1 && r2) m_owner = (m_last == 1) ? 2 : 1;
        else          m_owner = r1 ? 1 : 2;
        m_bits = 0;
        m_id = 0;
      end
    end else begin
      req  = (m_owner == 1) ? r1 : r2;
      addr = (m_owner == 1) ? a1 : a2;
      if (!req) begin
        m_gap = 1;
        m_conn = 0;
      end else if (!m_conn) begin
        m_id = m_id * 2 + int'(addr);
        m_bits++;
        if (m_bits == SSEL) begin
          if (m_id != 0) begin
            m_conn = 1;
            m_cnt = 0;
          end else begin
            m_err_inv = 1;
            m_gap = 1;
          end
        end
      end else begin
        m_cnt++;
        if (m_cnt == TMO) begin
          m_err_tmo = 1;
          m_gap = 1;
          m_conn = 0;
        end
      end
    end
  endtask

  task automatic compareModel();
    int g;
    g = (m_owner != 0 && !m_gap) ? m_owner : 0;
    checkOutput("bus_grant",    32'(bus_grant),    32'(g));
    checkOutput("slave_select", 32'(slave_select), m_conn ? 32'(m_id) : 32'd0);
    checkOutput("m1_grant",     32'(M1_GRANT),     32'(g == 1));
    checkOutput("m2_grant",     32'(M2_GRANT),     32'(g == 2));
    checkOutput("m1_ack",       32'(M1_ACK),       32'(m_conn && m_owner == 1));
    checkOutput("m2_ack",       32'(M2_ACK),       32'(m_conn && m_owner == 2));
    checkOutput("err_invalid",  32'(ERR_INVALID),  32'(m_err_inv));
    checkOutput("err_timeout",  32'(ERR_TIMEOUT),  32'(m_err_tmo));
  endtask

  // Drive one cycle of inputs, advance through the next rising edge, then check
  task automatic applyStimulus(input bit rst_n, input bit r1, input bit a1, input bit r2, input bit a2);
    RST = rst_n; M1_REQ = r1; M1_SLAVE_ADDR = a1; M2_REQ = r2; M2_SLAVE_ADDR = a2;
    @(posedge CLK);
    if (!rst_n) modelReset();
    else        modelEdge(r1, a1, r2, a2);
    #1;
    compareModel();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {22'd0, bus_grant, slave_select, M1_GRANT, M2_GRANT, M1_ACK, M2_ACK,
                      ERR_INVALID, ERR_TIMEOUT}, 32'd0);
  endtask

  initial begin
    int cnt;
    bit r1, r2;
    modelReset();
    RST = 1'b0; M1_REQ = 0; M1_SLAVE_ADDR = 0; M2_REQ = 0; M2_SLAVE_ADDR = 0;
    #1;
    checkAllZero("reset_async");

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i[0], i[1], !i[0], i[1]);
      checkAllZero("reset_hold");
    end
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkAllZero("idle_after_reset");

    // M1 single transaction to slave 2
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("m1_grant_T1", 32'(bus_grant), 32'd1);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("m1_no_ack_yet", 32'(M1_ACK), 32'd0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("m1_select", 32'(slave_select), 32'd2);
    checkOutput("m1_ack", 32'(M1_ACK), 32'd1);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkAllZero("m1_release");
    applyStimulus(1, 0, 0, 0, 0);
    checkAllZero("m1_idle");

    // Round-robin fairness from a fresh reset
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("rr_first_m1", 32'(bus_grant), 32'd1);
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("rr_m1_select3", 32'(slave_select), 32'd3);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkAllZero("rr_release");
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("rr_idle_gap", 32'(bus_grant), 32'd0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("rr_then_m2", 32'(bus_grant), 32'd2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Invalid ID from M2
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("inv_pulse", 32'(ERR_INVALID), 32'd1);
    checkOutput("inv_no_ack", 32'(M2_ACK), 32'd0);
    checkOutput("inv_release", 32'(bus_grant), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("inv_one_cycle", 32'(ERR_INVALID), 32'd0);
    checkOutput("inv_select", 32'(slave_select), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);

    // Timeout: M1 connected to slave 1 with REQ held
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("tmo_select1", 32'(slave_select), 32'd1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      if (!M1_ACK) break;
      cnt++;
    end
    checkOutput("tmo_cycles", 32'(cnt), 32'(TMO));
    checkOutput("tmo_pulse", 32'(ERR_TIMEOUT), 32'd1);
    checkOutput("tmo_release", 32'(bus_grant), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("tmo_one_cycle", 32'(ERR_TIMEOUT), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);

    // REQ drop on the timeout edge suppresses the error
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("tmo_last_cycle_ack", 32'(M1_ACK), 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("tmo_drop_no_err", 32'(ERR_TIMEOUT), 32'd0);
    checkOutput("tmo_drop_release", 32'(bus_grant), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);

    // Asynchronous reset while M2 is connected to slave 3
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("ar_m2_select3", 32'(slave_select), 32'd3);
    #3;
    RST = 1'b0;
    #1;
    checkAllZero("ar_immediate");
    modelReset();
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("ar_tie_m1", 32'(bus_grant), 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Randomized traffic against the model
    r1 = 0; r2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) r1 = !r1;
      if ($urandom_range(0, 19) == 0) r2 = !r2;
      applyStimulus($urandom_range(0, 499) != 0, r1, 1'($urandom), r2, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
